// File: rtl/exe_mem_pkg.sv
// exe_mem_pkg: shared constants and helpers for the EX->MEM pipeline register.
//   ST_EMPTY/ST_HALF/ST_FULL : skid buffer occupancy encoding
//   ZERO_REG                 : architectural zero register index (x0)
//   ZERO                     : cleared single-bit value
//   payload_width()          : packed payload width {waddr, we, wdata}
package exe_mem_pkg;

    localparam logic [1:0] ST_EMPTY = 2'b00;
    localparam logic [1:0] ST_HALF  = 2'b01;
    localparam logic [1:0] ST_FULL  = 2'b11;

    localparam int unsigned ZERO_REG = 0;
    localparam logic        ZERO     = 1'b0;

    // Packed payload layout is {waddr, we, wdata}.
    function automatic int unsigned payload_width(input int unsigned raddr_w,
                                                  input int unsigned rdata_w);
        return raddr_w + 1 + rdata_w;
    endfunction

endpackage

// File: rtl/pipe_skid_buf.sv
// pipe_skid_buf: generic 2-entry elastic buffer on a packed payload vector.
// Ports:
//   clk_i, rst_i   clock, synchronous active-high reset (clears payload)
//   flush_i        synchronous flush, drops both entries, payload untouched
//   valid_i/ready_o/data_i   upstream handshake (ready_o registered)
//   valid_o/ready_i/data_o   downstream handshake, data_o is the main register
//   valid_nxt_c/data_nxt_c   next-cycle view of valid_o/data_o for sideband regs
module pipe_skid_buf
    import exe_mem_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             flush_i,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic [WIDTH-1:0] data_i,
    output logic             valid_o,
    input  logic             ready_i,
    output logic [WIDTH-1:0] data_o,
    output logic             valid_nxt_c,
    output logic [WIDTH-1:0] data_nxt_c
);

    logic [1:0]       state_q, state_nxt;
    logic [WIDTH-1:0] m_q, m_nxt;
    logic [WIDTH-1:0] s_q, s_nxt;
    logic             valid_q;
    logic             ready_q;
    logic             in_xfer;
    logic             out_xfer;

    assign in_xfer  = valid_i & ready_q;
    assign out_xfer = valid_q & ready_i;

    // Next-state and register-load decode.
    always_comb begin
        state_nxt = state_q;
        m_nxt     = m_q;
        s_nxt     = s_q;
        case (state_q)
            ST_EMPTY: begin
                if (in_xfer) begin
                    m_nxt     = data_i;
                    state_nxt = ST_HALF;
                end
            end
            ST_HALF: begin
                if (in_xfer && out_xfer) begin
                    m_nxt = data_i;
                end else if (out_xfer) begin
                    state_nxt = ST_EMPTY;
                end else if (in_xfer) begin
                    s_nxt     = data_i;
                    state_nxt = ST_FULL;
                end
            end
            ST_FULL: begin
                if (out_xfer) begin
                    m_nxt     = s_q;
                    state_nxt = ST_HALF;
                end
            end
            default: begin
                state_nxt = ST_EMPTY;
            end
        endcase
        // Flush overrides every transition and drops any same-cycle input.
        if (flush_i) begin
            state_nxt = ST_EMPTY;
            m_nxt     = m_q;
            s_nxt     = s_q;
        end
    end

    // State, payload and handshake registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_EMPTY;
            m_q     <= '0;
            s_q     <= '0;
            valid_q <= 1'b0;
            ready_q <= 1'b1;
        end else begin
            state_q <= state_nxt;
            m_q     <= m_nxt;
            s_q     <= s_nxt;
            valid_q <= (state_nxt != ST_EMPTY);
            ready_q <= (state_nxt != ST_FULL);
        end
    end

    assign valid_o     = valid_q;
    assign ready_o     = ready_q;
    assign data_o      = m_q;
    assign valid_nxt_c = (state_nxt != ST_EMPTY);
    assign data_nxt_c  = m_nxt;

endmodule

// File: rtl/exe_mem_pipe.sv
// exe_mem_pipe: EX->MEM pipeline register with valid/ready handshake,
// 2-entry skid buffer, synchronous flush and x0 write suppression.
// Optional macro EXE_MEM_STALL_CNT_EN adds stall_cnt_o (cycles valid_o & ~ready_i).
// Ports:
//   clk_i, rst_i, flush_i                      clock, sync reset, sync flush
//   valid_i, ready_o, reg_waddr_i/we_i/wdata_i EX side
//   valid_o, ready_i, reg_waddr_o/we_o/wdata_o MEM side (reg_we_o is 0 when !valid_o)
//   stall_cnt_o                                32-bit stall counter (macro only)
module exe_mem_pipe
    import exe_mem_pkg::*;
#(
    parameter int unsigned RADDR_WIDTH   = 5,
    parameter int unsigned RDATA_WIDTH   = 32,
    parameter int unsigned ZERO_SUPPRESS = 1
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   flush_i,
    input  logic                   valid_i,
    output logic                   ready_o,
    input  logic [RADDR_WIDTH-1:0] reg_waddr_i,
    input  logic                   reg_we_i,
    input  logic [RDATA_WIDTH-1:0] reg_wdata_i,
    output logic                   valid_o,
    input  logic                   ready_i,
    output logic [RADDR_WIDTH-1:0] reg_waddr_o,
    output logic                   reg_we_o,
    output logic [RDATA_WIDTH-1:0] reg_wdata_o
`ifdef EXE_MEM_STALL_CNT_EN
    ,
    output logic [31:0]            stall_cnt_o
`endif
);

    localparam int unsigned PAYLOAD_W = payload_width(RADDR_WIDTH, RDATA_WIDTH);
    localparam int unsigned WE_BIT    = RDATA_WIDTH;

    logic                 we_in;
    logic [PAYLOAD_W-1:0] pl_in;
    logic [PAYLOAD_W-1:0] pl_out;
    logic [PAYLOAD_W-1:0] pl_nxt;
    logic                 valid_nxt;
    logic                 reg_we_q;
    logic                 unused_bits;

    // Writes to x0 are architecturally void; store them with we cleared.
    assign we_in = reg_we_i & ((ZERO_SUPPRESS == 0) ||
                               (reg_waddr_i != RADDR_WIDTH'(ZERO_REG)));
    assign pl_in = {reg_waddr_i, we_in, reg_wdata_i};

    pipe_skid_buf #(
        .WIDTH (PAYLOAD_W)
    ) u_skid (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .flush_i     (flush_i),
        .valid_i     (valid_i),
        .ready_o     (ready_o),
        .data_i      (pl_in),
        .valid_o     (valid_o),
        .ready_i     (ready_i),
        .data_o      (pl_out),
        .valid_nxt_c (valid_nxt),
        .data_nxt_c  (pl_nxt)
    );

    // Valid-masked write enable kept in its own flop so the output is registered.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            reg_we_q <= ZERO;
        end else begin
            reg_we_q <= valid_nxt & pl_nxt[WE_BIT];
        end
    end

    assign reg_waddr_o = pl_out[PAYLOAD_W-1 -: RADDR_WIDTH];
    assign reg_wdata_o = pl_out[RDATA_WIDTH-1:0];
    assign reg_we_o    = reg_we_q;

    // Bits carried through the buffer but consumed via the masked we flop.
    assign unused_bits = ^{pl_out[WE_BIT],
                           pl_nxt[PAYLOAD_W-1 -: RADDR_WIDTH],
                           pl_nxt[RDATA_WIDTH-1:0]};

`ifdef EXE_MEM_STALL_CNT_EN
    logic [31:0] stall_cnt_q;

    // Stall cycles; only reset clears it, wraps naturally.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stall_cnt_q <= '0;
        end else if (valid_o && !ready_i) begin
            stall_cnt_q <= stall_cnt_q + 32'd1;
        end
    end

    assign stall_cnt_o = stall_cnt_q;
`endif

endmodule

// File: tb/tb_exe_mem_pipe.sv
// tb_exe_mem_pipe: directed self-checking bench for exe_mem_pipe.
module tb_exe_mem_pipe;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        flush_i;
    logic        valid_i;
    logic        ready_o;
    logic [4:0]  reg_waddr_i;
    logic        reg_we_i;
    logic [31:0] reg_wdata_i;
    logic        valid_o;
    logic        ready_i;
    logic [4:0]  reg_waddr_o;
    logic        reg_we_o;
    logic [31:0] reg_wdata_o;
`ifdef EXE_MEM_STALL_CNT_EN
    logic [31:0] stall_cnt_o;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clk_i = ~clk_i;

    exe_mem_pipe #(
        .RADDR_WIDTH   (5),
        .RDATA_WIDTH   (32),
        .ZERO_SUPPRESS (1)
    ) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .flush_i     (flush_i),
        .valid_i     (valid_i),
        .ready_o     (ready_o),
        .reg_waddr_i (reg_waddr_i),
        .reg_we_i    (reg_we_i),
        .reg_wdata_i (reg_wdata_i),
        .valid_o     (valid_o),
        .ready_i     (ready_i),
        .reg_waddr_o (reg_waddr_o),
        .reg_we_o    (reg_we_o),
        .reg_wdata_o (reg_wdata_o)
`ifdef EXE_MEM_STALL_CNT_EN
        ,
        .stall_cnt_o (stall_cnt_o)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1 time unit later.
    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic drive(input logic v, input logic [4:0] a, input logic we, input logic [31:0] d);
        valid_i     = v;
        reg_waddr_i = a;
        reg_we_i    = we;
        reg_wdata_i = d;
    endtask

    task automatic check_out(input string tag, input logic v, input logic [4:0] a,
                             input logic we, input logic [31:0] d, input logic rdy);
        check({tag, ".valid"}, 32'(valid_o), 32'(v));
        check({tag, ".waddr"}, 32'(reg_waddr_o), 32'(a));
        check({tag, ".we"},    32'(reg_we_o), 32'(we));
        check({tag, ".wdata"}, reg_wdata_o, d);
        check({tag, ".ready"}, 32'(ready_o), 32'(rdy));
    endtask

    initial begin
        rst_i   = 1'b1;
        flush_i = 1'b0;
        ready_i = 1'b1;
        drive(1'b1, 5'd9, 1'b1, 32'h99);
        #1;

        // Reset held two cycles with valid_i asserted.
        step();
        step();
        check_out("reset", 1'b0, 5'd0, 1'b0, 32'h0, 1'b1);
        rst_i = 1'b0;
        drive(1'b0, 5'd0, 1'b0, 32'h0);
        step();
        check_out("idle", 1'b0, 5'd0, 1'b0, 32'h0, 1'b1);

        // Streaming with MEM always ready.
        drive(1'b1, 5'd3, 1'b1, 32'h11);
        step();
        check_out("stream0", 1'b1, 5'd3, 1'b1, 32'h11, 1'b1);
        drive(1'b1, 5'd4, 1'b1, 32'h22);
        step();
        check_out("stream1", 1'b1, 5'd4, 1'b1, 32'h22, 1'b1);
        drive(1'b0, 5'd0, 1'b0, 32'h0);
        step();
        check_out("stream_drain", 1'b0, 5'd4, 1'b0, 32'h22, 1'b1);

        // Back-pressure: fill both entries.
        ready_i = 1'b0;
        drive(1'b1, 5'd5, 1'b1, 32'hAA);
        step();
        check_out("bp_a", 1'b1, 5'd5, 1'b1, 32'hAA, 1'b1);
        drive(1'b1, 5'd6, 1'b1, 32'hBB);
        step();
        check_out("bp_full", 1'b1, 5'd5, 1'b1, 32'hAA, 1'b0);
        drive(1'b1, 5'd8, 1'b1, 32'hEE);   // must not be accepted while full
        step();
        check_out("bp_hold", 1'b1, 5'd5, 1'b1, 32'hAA, 1'b0);
        drive(1'b0, 5'd0, 1'b0, 32'h0);
        ready_i = 1'b1;
        step();
        check_out("bp_b", 1'b1, 5'd6, 1'b1, 32'hBB, 1'b1);
        step();
        check_out("bp_empty", 1'b0, 5'd6, 1'b0, 32'hBB, 1'b1);

        // Flush while full drops both entries and the same-cycle input.
        ready_i = 1'b0;
        drive(1'b1, 5'd5, 1'b1, 32'hAA);
        step();
        drive(1'b1, 5'd6, 1'b1, 32'hBB);
        step();
        check("pre_flush.ready", 32'(ready_o), 32'd0);
        flush_i = 1'b1;
        drive(1'b1, 5'd7, 1'b1, 32'hCC);
        step();
        check_out("flush", 1'b0, 5'd5, 1'b0, 32'hAA, 1'b1);
        flush_i = 1'b0;
        drive(1'b0, 5'd0, 1'b0, 32'h0);
        ready_i = 1'b1;
        step();
        check_out("post_flush", 1'b0, 5'd5, 1'b0, 32'hAA, 1'b1);

        // x0 write suppression: we dropped, address and data kept.
        drive(1'b1, 5'd0, 1'b1, 32'hDEAD);
        step();
        check_out("x0", 1'b1, 5'd0, 1'b0, 32'hDEAD, 1'b1);
        // Non-zero address with we=0 stays we=0.
        drive(1'b1, 5'd2, 1'b0, 32'h1234);
        step();
        check_out("we0", 1'b1, 5'd2, 1'b0, 32'h1234, 1'b1);

        // Reset mid-transfer discards entries and clears payload.
        ready_i = 1'b0;
        drive(1'b1, 5'd10, 1'b1, 32'h55);
        step();
        rst_i = 1'b1;
        drive(1'b1, 5'd11, 1'b1, 32'h66);
        step();
        check_out("reset_mid", 1'b0, 5'd0, 1'b0, 32'h0, 1'b1);
        rst_i = 1'b0;
        drive(1'b0, 5'd0, 1'b0, 32'h0);
        ready_i = 1'b1;
        step();
        check_out("reset_mid_after", 1'b0, 5'd0, 1'b0, 32'h0, 1'b1);

`ifdef EXE_MEM_STALL_CNT_EN
        // Stall counter: 10 stalled cycles, survives flush, cleared by reset.
        check("stall.zero", stall_cnt_o, 32'd0);
        ready_i = 1'b0;
        drive(1'b1, 5'd12, 1'b1, 32'h77);
        step();
        drive(1'b0, 5'd0, 1'b0, 32'h0);
        check("stall.load", stall_cnt_o, 32'd0);
        for (int i = 0; i < 10; i++) step();
        check("stall.ten", stall_cnt_o, 32'd10);
        ready_i = 1'b1;
        flush_i = 1'b1;
        step();
        flush_i = 1'b0;
        check("stall.flush", stall_cnt_o, 32'd10);
        check("stall.flush_valid", 32'(valid_o), 32'd0);
        rst_i = 1'b1;
        step();
        rst_i = 1'b0;
        check("stall.reset", stall_cnt_o, 32'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
